// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - shared opcode constants, FSM encoding and entry sizing for id_ex_stage
package id_ex_pkg;

  localparam logic [4:0] ALUOP_HALT      = 5'b00000;
  localparam logic [4:0] ALUOP_ILLEGAL_1 = 5'b00001;
  localparam logic [4:0] ALUOP_ILLEGAL_2 = 5'b00010;
  localparam logic [4:0] ALUOP_ILLEGAL_3 = 5'b00011;
  localparam logic [4:0] ALUOP_ADD       = 5'b11011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Packed entry: alu_op, funct, a, b, wr_reg, wr_en, pc
  function automatic int entry_w(input int data_w, input int reg_aw);
    return 5 + 2 + data_w + data_w + reg_aw + 1 + data_w;
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return (op == ALUOP_ILLEGAL_1) || (op == ALUOP_ILLEGAL_2) || (op == ALUOP_ILLEGAL_3);
  endfunction

endpackage

// File: rtl/id_ex_stage_skid.sv
// rtl/id_ex_stage_skid.sv - pipe_skid_buf: generic 2-entry valid/ready buffer with flush
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] in_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent0, ent1;

  // ent0 is always the head so outputs come straight from a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_data;
          else               ent1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_data;
          end else begin
            ent0 <= ent1;
            ent1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = ent0;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute stage with halt/illegal filtering and flush
// Optional stall counter enabled by ID_EX_STALL_CNT_EN.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_alu_op,
  input  logic [1:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_wr_reg,
  input  logic              in_wr_en,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_alu_op,
  output logic [1:0]        out_funct,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [REG_AW-1:0] out_wr_reg,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] out_pc,
  output logic              halted,
  output logic              err,
  output logic [15:0]       stall_cycles
);

  localparam int ENT_W = entry_w(DATA_W, REG_AW);

  state_t           state, state_next;
  logic [1:0]       count;
  logic             accept, pop, push, is_halt, is_ill, empty_next;
  logic [ENT_W-1:0] in_entry, head;

  assign is_halt   = (in_alu_op == ALUOP_HALT);
  assign is_ill    = is_illegal(in_alu_op);
  assign in_ready  = (state == ST_RUN) && (count != 2'd2);
  assign out_valid = (state != ST_HALTED) && (count != 2'd0);
  assign accept    = in_valid && in_ready && !flush;
  assign push      = accept && !is_halt && !is_ill;
  assign pop       = out_valid && out_ready && !flush;
  assign halted    = (state == ST_HALTED);
  assign empty_next = (count == 2'd0) || ((count == 2'd1) && pop);

  assign in_entry = {in_alu_op, in_funct, in_rs_data, (in_use_imm ? in_imm : in_rt_data),
                     in_wr_reg, in_wr_en, in_pc};
  assign {out_alu_op, out_funct, out_a, out_b, out_wr_reg, out_wr_en, out_pc} = head;

  pipe_skid_buf #(.W(ENT_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .in_data  (in_entry),
    .pop      (pop),
    .flush    (flush && (state != ST_HALTED)),
    .out_data (head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Halting on an already-empty buffer skips DRAIN so halted rises the next cycle
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN:    if (accept && is_halt) state_next = empty_next ? ST_HALTED : ST_DRAIN;
      ST_DRAIN:  if (flush) state_next = ST_RUN;
                 else if (empty_next) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err <= 1'b0;
    else if (accept && is_ill) err <= 1'b1;
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= 16'd0;
    else if (out_valid && !out_ready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly upstream of the ALU control decoder. Each cycle it accepts one decoded instruction (5-bit ALU opcode, 2-bit function field, operands, writeback info) from decode, buffers it in a 2-entry skid buffer, and presents it to execute with a valid/ready handshake. It also detects HALT and illegal opcodes so that the ALU control decoder and the ALU only ever see legal, live instructions. Flush support discards wrong-path instructions on a taken branch or jump.

## Interface
Parameters:
- DATA_W, 16, operand, immediate and PC width
- REG_AW, 3, register-file address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_alu_op  in  5  ALU opcode (instruction bits [15:11])
- in_funct  in  2  instruction bits [1:0]
- in_rs_data  in  DATA_W  source A operand
- in_rt_data  in  DATA_W  source B register operand
- in_imm  in  DATA_W  extended immediate
- in_use_imm  in  1  select in_imm as operand B
- in_wr_reg  in  REG_AW  destination register
- in_wr_en  in  1  writeback enable
- in_pc  in  DATA_W  PC+2 of the instruction
- flush  in  1  discard all buffered and incoming instructions
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head entry
- out_alu_op, out_funct, out_a, out_b, out_wr_reg, out_wr_en, out_pc  out  5/2/DATA_W/DATA_W/REG_AW/1/DATA_W  head entry fields
- halted  out  1  processor halted (terminal)
- err  out  1  sticky illegal-opcode flag
- stall_cycles  out  16  back-pressure counter (see Configuration)

## Operation
- Accept: in_valid && in_ready && !flush. At capture, out_a = in_rs_data and out_b = in_use_imm ? in_imm : in_rt_data.
- Pop: out_valid && out_ready. FIFO order is preserved. Accept and pop in the same cycle leaves the count unchanged.
- FSM states:
  - RUN: in_ready = (count < 2).
  - DRAIN: HALT accepted; in_ready = 0. Go to HALTED when count == 0.
  - HALTED: terminal; in_ready = 0, out_valid = 0, halted = 1. Leaves this state only on reset.
- HALT (alu_op 5'b00000): consumed, never written into the buffer. Transition RUN -> DRAIN.
- Illegal opcodes are 5'b00001, 5'b00010 and 5'b00011. An accepted illegal instruction sets err = 1 and is dropped. err is cleared only by reset.
- All other codes are forwarded unchanged.
- flush:
  - Empties the buffer and discards the same-cycle input.
  - DRAIN -> RUN (the pending halt is cancelled).
  - No effect in HALTED; no effect on err.
  - flush together with out_ready: no pop is reported; the buffer is simply emptied.
- Reset values: count = 0, state RUN, out_valid 0, in_ready 1, halted 0, err 0, stall_cycles 0, all data outputs 0.

## Timing
- Latency: accepted in cycle N, out_valid in cycle N+1.
- Throughput: 1 instruction per cycle.
- in_ready is a registered function of count and state. It has no combinational path from out_ready.
- Output fields are driven directly from the head-entry registers.
- Once out_valid is high, it and all output fields hold stable until a pop, a flush, or reset.
- Reset asserted mid-operation drops all entries immediately, asynchronously.
- halted rises in the cycle after the last pop in DRAIN. If the buffer is already empty when HALT is accepted, halted rises in cycle N+1.

## Configuration
- ID_EX_STALL_CNT_EN defined: stall_cycles increments on every cycle with out_valid && !out_ready, saturates at 16'hFFFF, and is cleared only by reset.
- ID_EX_STALL_CNT_EN undefined: stall_cycles is tied to 0 and no counter logic is synthesised.

## Structure
- Shared package holds:
  - ALU opcode constants (ALUOP_HALT, ALUOP_ILLEGAL_* and the existing class encodings)
  - FSM state encoding (RUN/DRAIN/HALTED)
  - entry width derived from DATA_W/REG_AW
- Sub-module pipe_skid_buf: generic 2-entry valid/ready buffer with flush, parameterised by entry width. It holds the packed entry.
- Top level contains the FSM, opcode classification, operand-B mux and the optional counter.

## Test plan
- Back-to-back ADD-class (alu_op 11011) with out_ready = 1 -> one output per cycle, 1-cycle latency, out_b = rt_data when in_use_imm = 0 and imm when 1.
- out_ready = 0 for 4 cycles while in_valid = 1 -> 2 entries captured, in_ready = 0, order preserved when released; stall_cycles = 4 with macro defined, 0 without.
- Accept alu_op 5'b00010 -> err = 1, nothing forwarded; following legal instruction forwarded normally; err stays 1.
- Two entries buffered, then HALT accepted, out_ready = 1 -> both pop, halted = 1 in the cycle after the last pop, in_ready stays 0 thereafter.
- HALT accepted with 2 entries blocked, then flush -> buffer empty, state RUN, in_ready = 1, halted = 0.
- rst_n pulsed low while out_valid = 1 -> out_valid, halted and err are 0 immediately; first instruction after release appears one cycle after acceptance.
